// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - LoongArch32 execute stage: ALU, 32-step iterative divider, data-SRAM request
// Registers the decode bundle and packs {res_from_mem, gr_we, dest, result, pc} for MEM.
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 153,
  parameter int ES_TO_MS_BUS_WD = 71
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [4:0]                 es_to_ds_dest,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  logic                       es_valid;
  logic                       es_ready_go;
  logic [DS_TO_ES_BUS_WD-1:0] bus_r;

  logic        div_en;
  logic [1:0]  div_op;
  logic [11:0] alu_op;
  logic        src1_is_pc, src2_is_imm, res_from_mem, gr_we, mem_we;
  logic [4:0]  dest;
  logic [31:0] imm, rj_value, rkd_value, pc;

  assign {div_en, div_op, alu_op, src1_is_pc, src2_is_imm, res_from_mem, gr_we,
          mem_we, dest, imm, rj_value, rkd_value, pc} = bus_r;

  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign es_to_ds_dest  = dest & {5{es_valid}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_r <= '0;
    end else if (ds_to_es_valid && es_allowin) begin
      bus_r <= ds_to_es_bus;
    end
  end

  logic [31:0] src1, src2, alu_result;
  logic [31:0] add_res, sub_res, sra_res;
  logic [4:0]  sh;

  assign src1    = src1_is_pc ? pc : rj_value;
  assign src2    = src2_is_imm ? imm : rkd_value;
  assign sh      = src2[4:0];
  assign add_res = src1 + src2;
  assign sub_res = src1 - src2;
  assign sra_res = $unsigned($signed(src1) >>> sh);

  // alu_op is one-hot, so an AND-OR mux yields 0 when no bit is set
  assign alu_result =
      ({32{alu_op[0]}}  & add_res)
    | ({32{alu_op[1]}}  & sub_res)
    | ({32{alu_op[2]}}  & {31'd0, $signed(src1) < $signed(src2)})
    | ({32{alu_op[3]}}  & {31'd0, src1 < src2})
    | ({32{alu_op[4]}}  & (src1 & src2))
    | ({32{alu_op[5]}}  & ~(src1 | src2))
    | ({32{alu_op[6]}}  & (src1 | src2))
    | ({32{alu_op[7]}}  & (src1 ^ src2))
    | ({32{alu_op[8]}}  & (src1 << sh))
    | ({32{alu_op[9]}}  & (src1 >> sh))
    | ({32{alu_op[10]}} & sra_res)
    | ({32{alu_op[11]}} & src2);

  div_state_t  state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem, quo, divisor;
  logic        q_neg, r_neg;
  logic        div_start, div_busy;
  logic        div_signed;
  logic [32:0] partial, diff;
  logic        ge;
  logic [31:0] quotient, remainder;

  assign div_signed = !div_op[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (es_valid && div_en) state_nxt = BUSY;
      BUSY:    if (cnt == 5'd31)       state_nxt = DONE;
      DONE:    if (ms_allowin)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_start   = (state == IDLE) && es_valid && div_en;
    div_busy    = (state == BUSY);
    es_ready_go = !div_en || (state == DONE);
  end

  // Restoring step; explicit compare keeps divide-by-zero at all-ones quotient
  assign partial = {rem, quo[31]};
  assign ge      = partial >= {1'b0, divisor};
  assign diff    = partial - {1'b0, divisor};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
    end else if (div_start) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= (div_signed && rj_value[31])  ? -rj_value  : rj_value;
      divisor <= (div_signed && rkd_value[31]) ? -rkd_value : rkd_value;
      q_neg   <= div_signed && (rj_value[31] ^ rkd_value[31]) && (rkd_value != 32'd0);
      r_neg   <= div_signed && rj_value[31];
    end else if (div_busy) begin
      cnt <= cnt + 5'd1;
      rem <= ge ? diff[31:0] : partial[31:0];
      quo <= {quo[30:0], ge};
    end
  end

  assign quotient  = q_neg ? -quo : quo;
  assign remainder = r_neg ? -rem : rem;

  logic [31:0] result;
  assign result = div_en ? (div_op[0] ? remainder : quotient) : alu_result;

  assign es_to_ms_bus = {res_from_mem, gr_we, dest, result, pc};

  assign data_sram_en    = es_valid && es_ready_go && ms_allowin && (res_from_mem || mem_we);
  assign data_sram_we    = {4{mem_we && data_sram_en}};
  assign data_sram_addr  = es_valid ? alu_result : 32'd0;
  assign data_sram_wdata = es_valid ? rkd_value  : 32'd0;

endmodule
